// File: rtl/fft_butterfly_pkg.sv
// Shared FFT datapath defaults: sample/twiddle formats, FFT length, rounding and saturation constants.
// Imported by every FFT stage so all stages agree on Q formats and limits.
package fft_butterfly_pkg;

  localparam int DEF_Q_IN    = 15;
  localparam int DEF_Q_COEFF = 15;
  localparam int DEF_Q_OUT   = 15;
  localparam int DEF_N       = 256;

  // Half-LSB added before dropping q fractional bits (round half up).
  function automatic int round_const(input int q);
    return 1 << (q - 1);
  endfunction

  function automatic int sat_max(input int q);
    return (1 << q) - 1;
  endfunction

  function automatic int sat_min(input int q);
    return -(1 << q);
  endfunction

endpackage

// File: rtl/fft_butterfly_cmul_q15.sv
// Pipelined complex multiply p = x * w with round-half-up and arithmetic shift by QC.
// Latency 2 cycles (products, then combine/round/shift); valid rides alongside, no backpressure.
module fft_butterfly_cmul_q15
  import fft_butterfly_pkg::*;
#(
  parameter int QI = DEF_Q_IN,
  parameter int QC = DEF_Q_COEFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic signed [QI:0] x_real,
  input  logic signed [QI:0] x_imag,
  input  logic signed [QC:0] w_real,
  input  logic signed [QC:0] w_imag,
  output logic               valid_out,
  output logic signed [QI+2:0] p_real,
  output logic signed [QI+2:0] p_imag
);

  // Full-width products: -2^QI * -2^QC = 2^(QI+QC) still fits as a positive value.
  localparam int PW = QI + QC + 2;
  localparam int OW = QI + 3;
  localparam logic signed [PW:0] RND = (PW+1)'(round_const(QC));

  logic                 s2_vld;
  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW:0]   sum_r, sum_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld <= 1'b0;
      rr     <= '0;
      ii     <= '0;
      ri     <= '0;
      ir     <= '0;
    end else begin
      s2_vld <= valid_in;
      rr     <= PW'(x_real) * PW'(w_real);
      ii     <= PW'(x_imag) * PW'(w_imag);
      ri     <= PW'(x_real) * PW'(w_imag);
      ir     <= PW'(x_imag) * PW'(w_real);
    end
  end

  always_comb begin
    sum_r = (PW+1)'(rr) - (PW+1)'(ii) + RND;
    sum_i = (PW+1)'(ri) + (PW+1)'(ir) + RND;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      p_real    <= '0;
      p_imag    <= '0;
    end else begin
      valid_out <= s2_vld;
      p_real    <= OW'(sum_r >>> QC);
      p_imag    <= OW'(sum_i >>> QC);
    end
  end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly y0 = x0 + W*x1, y1 = x0 - W*x1, 4-cycle latency, one pair per cycle, no backpressure.
// Build option FFT_BF_SCALE_EN: halve each result (per-stage 1/2 scaling) instead of full-scale saturation.
module fft_butterfly
  import fft_butterfly_pkg::*;
#(
  parameter int Q_IN    = DEF_Q_IN,
  parameter int Q_COEFF = DEF_Q_COEFF,
  parameter int Q_OUT   = DEF_Q_OUT,
  parameter int N       = DEF_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic signed [Q_IN:0]  data_in_real_0,
  input  logic signed [Q_IN:0]  data_in_imag_0,
  input  logic signed [Q_IN:0]  data_in_real_1,
  input  logic signed [Q_IN:0]  data_in_imag_1,
  input  logic signed [Q_COEFF:0] coeff_in_real,
  input  logic signed [Q_COEFF:0] coeff_in_imag,
  output logic                  valid_out,
  output logic signed [Q_OUT:0] data_out_real_0,
  output logic signed [Q_OUT:0] data_out_imag_0,
  output logic signed [Q_OUT:0] data_out_real_1,
  output logic signed [Q_OUT:0] data_out_imag_1,
  output logic                  frame_done
);

  localparam int SW    = Q_IN + 3;
  localparam int CNT_W = $clog2(N / 2);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(N / 2 - 1);
  localparam logic signed [SW-1:0] OUT_MAX = SW'(sat_max(Q_OUT));
  localparam logic signed [SW-1:0] OUT_MIN = SW'(sat_min(Q_OUT));

  logic                  s1_vld;
  logic signed [Q_IN:0]  s1_x0r, s1_x0i, s1_x1r, s1_x1i;
  logic signed [Q_COEFF:0] s1_wr, s1_wi;
  logic signed [Q_IN:0]  s2_x0r, s2_x0i, s3_x0r, s3_x0i;
  logic                  s3_vld;
  logic signed [SW-1:0]  s3_pr, s3_pi;
  logic signed [SW-1:0]  sum0_r, sum0_i, sum1_r, sum1_i;
  logic [CNT_W-1:0]      bfly_cnt;

  function automatic logic signed [Q_OUT:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
`ifdef FFT_BF_SCALE_EN
    t = v >>> 1;
`else
    t = v;
`endif
    if (t > OUT_MAX)      return (Q_OUT+1)'(OUT_MAX);
    else if (t < OUT_MIN) return (Q_OUT+1)'(OUT_MIN);
    else                  return (Q_OUT+1)'(t);
  endfunction

  // S1 input register plus the two-deep x0 delay matching the multiplier latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_x0r <= '0;
      s1_x0i <= '0;
      s1_x1r <= '0;
      s1_x1i <= '0;
      s1_wr  <= '0;
      s1_wi  <= '0;
      s2_x0r <= '0;
      s2_x0i <= '0;
      s3_x0r <= '0;
      s3_x0i <= '0;
    end else begin
      s1_vld <= valid_in;
      s1_x0r <= data_in_real_0;
      s1_x0i <= data_in_imag_0;
      s1_x1r <= data_in_real_1;
      s1_x1i <= data_in_imag_1;
      s1_wr  <= coeff_in_real;
      s1_wi  <= coeff_in_imag;
      s2_x0r <= s1_x0r;
      s2_x0i <= s1_x0i;
      s3_x0r <= s2_x0r;
      s3_x0i <= s2_x0i;
    end
  end

  fft_butterfly_cmul_q15 #(
    .QI (Q_IN),
    .QC (Q_COEFF)
  ) u_cmul (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (s1_vld),
    .x_real    (s1_x1r),
    .x_imag    (s1_x1i),
    .w_real    (s1_wr),
    .w_imag    (s1_wi),
    .valid_out (s3_vld),
    .p_real    (s3_pr),
    .p_imag    (s3_pi)
  );

  always_comb begin
    sum0_r = SW'(s3_x0r) + s3_pr;
    sum0_i = SW'(s3_x0i) + s3_pi;
    sum1_r = SW'(s3_x0r) - s3_pr;
    sum1_i = SW'(s3_x0i) - s3_pi;
  end

  // Output data only loads on a valid result so it holds across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out       <= 1'b0;
      frame_done      <= 1'b0;
      bfly_cnt        <= '0;
      data_out_real_0 <= '0;
      data_out_imag_0 <= '0;
      data_out_real_1 <= '0;
      data_out_imag_1 <= '0;
    end else begin
      valid_out  <= s3_vld;
      frame_done <= s3_vld && (bfly_cnt == LAST);
      if (s3_vld) begin
        bfly_cnt        <= (bfly_cnt == LAST) ? '0 : bfly_cnt + CNT_W'(1);
        data_out_real_0 <= scale_sat(sum0_r);
        data_out_imag_0 <= scale_sat(sum0_i);
        data_out_real_1 <= scale_sat(sum1_r);
        data_out_imag_1 <= scale_sat(sum1_i);
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: hand-computed vectors, latency, hold, saturation, framing, async reset.
// Expected values follow FFT_BF_SCALE_EN when the bench is built with it defined.
module tb_fft_butterfly;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in_real_0 = '0, data_in_imag_0 = '0, data_in_real_1 = '0, data_in_imag_1 = '0;
  logic [15:0] coeff_in_real = '0, coeff_in_imag = '0;
  logic        valid_out, frame_done;
  logic [15:0] data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] expq[$];

  fft_butterfly dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .data_in_real_0  (data_in_real_0),
    .data_in_imag_0  (data_in_imag_0),
    .data_in_real_1  (data_in_real_1),
    .data_in_imag_1  (data_in_imag_1),
    .coeff_in_real   (coeff_in_real),
    .coeff_in_imag   (coeff_in_imag),
    .valid_out       (valid_out),
    .data_out_real_0 (data_out_real_0),
    .data_out_imag_0 (data_out_imag_0),
    .data_out_real_1 (data_out_real_1),
    .data_out_imag_1 (data_out_imag_1),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat16(input longint v);
    longint t;
`ifdef FFT_BF_SCALE_EN
    t = v >>> 1;
`else
    t = v;
`endif
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return t[15:0];
  endfunction

  // Reference: exact complex product, round half up at 2^-15, then butterfly.
  function automatic logic [63:0] model(input logic signed [15:0] x0r, x0i, x1r, x1i, wr, wi);
    longint pr, pi;
    pr = (longint'(x1r) * longint'(wr) - longint'(x1i) * longint'(wi) + 16384) >>> 15;
    pi = (longint'(x1r) * longint'(wi) + longint'(x1i) * longint'(wr) + 16384) >>> 15;
    return {sat16(longint'(x0r) + pr), sat16(longint'(x0i) + pi),
            sat16(longint'(x0r) - pr), sat16(longint'(x0i) - pi)};
  endfunction

  function automatic logic [63:0] outs();
    return {data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1};
  endfunction

  task automatic drive_rand(input bit push);
    data_in_real_0 = 16'($urandom);
    data_in_imag_0 = 16'($urandom);
    data_in_real_1 = 16'($urandom);
    data_in_imag_1 = 16'($urandom);
    coeff_in_real  = 16'($urandom);
    coeff_in_imag  = 16'($urandom);
    valid_in       = 1'b1;
    if (push)
      expq.push_back(model(data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
                           coeff_in_real, coeff_in_imag));
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({valid_out, frame_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00", {valid_out, frame_done});
    end
    n_cmp++;
    if (outs() !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", outs());
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pair(input string name, input logic [15:0] x0r, x0i, x1r, x1i, wr, wi,
                           input logic [63:0] want);
    @(negedge clk);
    data_in_real_0 = x0r; data_in_imag_0 = x0i;
    data_in_real_1 = x1r; data_in_imag_1 = x1i;
    coeff_in_real  = wr;  coeff_in_imag  = wi;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early_valid: cycle %0d got %b want 0", name, c, valid_out);
      end
      if (c < 3) @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if ({valid_out, frame_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_valid_at_4: got %b want 10", name, {valid_out, frame_done});
    end
    n_cmp++;
    if (outs() !== want) begin
      n_fail++;
      $display("FAIL %s_data: got %h want %h", name, outs(), want);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0 || outs() !== want) begin
      n_fail++;
      $display("FAIL %s_hold: got vld=%b %h want vld=0 %h", name, valid_out, outs(), want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
  endtask

  // Sends n_b2b back-to-back butterflies then n_sp spaced 3 cycles apart, scoreboarding every output.
  task automatic run_frames(input string name, input int n_b2b, input int n_sp);
    int total = n_b2b + n_sp;
    int seen  = 0;
    fork
      begin
        for (int i = 0; i < n_b2b; i++) begin
          @(negedge clk);
          drive_rand(1'b1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < n_sp; i++) begin
          drive_rand(1'b1);
          @(negedge clk);
          valid_in = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
      begin
        logic [63:0] w;
        for (int cyc = 0; cyc < 2000 && seen < total; cyc++) begin
          @(negedge clk);
          if (valid_out === 1'b1) begin
            w = (expq.size() > 0) ? expq.pop_front() : 64'hx;
            n_cmp++;
            if (outs() !== w) begin
              n_fail++;
              $display("FAIL %s_data[%0d]: got %h want %h", name, seen, outs(), w);
            end
            n_cmp++;
            if (frame_done !== ((seen % 128) == 127)) begin
              n_fail++;
              $display("FAIL %s_frame_done[%0d]: got %b want %b", name, seen, frame_done,
                       ((seen % 128) == 127));
            end
            seen++;
          end else if (frame_done !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_stray_frame_done: got %b want 0", name, frame_done);
          end
        end
      end
    join
    repeat (6) @(negedge clk);
    n_cmp++;
    if (seen != total || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_count: got %0d outputs want %0d", name, seen, total);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frames("b2b_then_spaced", 128, 128);
  endtask

  task automatic test_async_reset();
    bit stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_rand(1'b0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({valid_out, frame_done} !== 2'b00 || outs() !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got vld=%b fd=%b %h want 0", valid_out, frame_done, outs());
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_out !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_fail++;
      $display("FAIL async_reset_flush: got valid_out after reset want none");
    end
    run_frames("post_reset_frame", 128, 0);
  endtask

  initial begin
    test_reset();
`ifdef FFT_BF_SCALE_EN
    test_pair("unity_w",  16'h1000, 16'h0, 16'h0800, 16'h0, 16'h7FFF, 16'h0,
              {16'h0C00, 16'h0000, 16'h0400, 16'h0000});
    test_pair("minus_j",  16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h8000,
              {16'h0000, 16'hFE00, 16'h0000, 16'h0200});
    test_pair("saturate", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0,
              {16'h6FFF, 16'h0000, 16'h0000, 16'h0000});
    test_pair("w_minus1", 16'h0, 16'h0, 16'h8000, 16'h8000, 16'h8000, 16'h0,
              {16'h4000, 16'h4000, 16'hC000, 16'hC000});
`else
    test_pair("unity_w",  16'h1000, 16'h0, 16'h0800, 16'h0, 16'h7FFF, 16'h0,
              {16'h1800, 16'h0000, 16'h0800, 16'h0000});
    test_pair("minus_j",  16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h8000,
              {16'h0000, 16'hFC00, 16'h0000, 16'h0400});
    test_pair("saturate", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0,
              {16'h7FFF, 16'h0000, 16'h0001, 16'h0000});
    test_pair("w_minus1", 16'h0, 16'h0, 16'h8000, 16'h8000, 16'h8000, 16'h0,
              {16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000});
`endif
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
